// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction-memory, redirect and output-queue signals of the fetch stage.
interface instr_fetch_if #(
   parameter int PC_W    = 9,
   parameter int INSTR_W = 32
);
   logic               imem_en;
   logic [PC_W-1:0]    imem_addr;
   logic [INSTR_W-1:0] imem_rdata;
   logic               redirect_valid;
   logic [PC_W-1:0]    redirect_pc;
   logic               out_valid;
   logic               out_ready;
   logic [INSTR_W-1:0] out_instr;
   logic [PC_W-1:0]    out_pc;
   modport master (
      output imem_en, imem_addr, out_valid, out_instr, out_pc,
      input  imem_rdata, redirect_valid, redirect_pc, out_ready
   );
   modport slave (
      input  imem_en, imem_addr, out_valid, out_instr, out_pc,
      output imem_rdata, redirect_valid, redirect_pc, out_ready
   );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: owns the fetch PC, reads a synchronous imem, queues 2 instructions with redirect flush.
// Define JUMP_PREDICT_EN to restart fetch at the target of an enqueued j (opcode 20).
module instr_fetch #(
   parameter int PC_W       = 9,
   parameter int INSTR_W    = 32,
   parameter int FIFO_DEPTH = 2
) (
   input logic           clk,
   input logic           rst_n,
   instr_fetch_if.master bus
);
   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
   localparam logic [1:0] DEPTH = 2'(FIFO_DEPTH);
   state_t             state, state_nx;
   logic [PC_W-1:0]    fetch_pc, tag_pc, s_pc, jump_pc;
   logic [INSTR_W-1:0] s_instr;
   logic               inflight, s_valid, pop, push, jump, issue;
   logic [1:0]         occ;
   assign pop     = bus.out_valid & bus.out_ready;
   assign push    = inflight & ~bus.redirect_valid;
   // queue entries plus the outstanding read, after this cycle's pop
   assign occ     = {1'b0, bus.out_valid} + {1'b0, s_valid} + {1'b0, inflight} - {1'b0, pop};
   assign jump_pc = bus.imem_rdata[PC_W-1:0];
`ifdef JUMP_PREDICT_EN
   assign jump    = push & (bus.imem_rdata[31:26] == 6'd20);
`else
   assign jump    = 1'b0;
`endif
   always_comb begin
      state_nx      = bus.redirect_valid ? FLUSH : RUN;
      issue         = (state == RUN) & ~bus.redirect_valid & (occ < DEPTH);
      bus.imem_en   = issue;
      bus.imem_addr = fetch_pc;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc      <= '0;
         tag_pc        <= '0;
         inflight      <= 1'b0;
         s_valid       <= 1'b0;
         s_instr       <= '0;
         s_pc          <= '0;
         bus.out_valid <= 1'b0;
         bus.out_instr <= '0;
         bus.out_pc    <= '0;
      end else begin
         fetch_pc <= bus.redirect_valid ? bus.redirect_pc : jump ? jump_pc : issue ? fetch_pc + 1'b1 : fetch_pc;
         inflight <= issue & ~jump;
         if (issue) tag_pc <= fetch_pc;
         // head register keeps its last contents when the queue drains
         if (bus.redirect_valid) begin
            bus.out_valid <= 1'b0;
            s_valid       <= 1'b0;
         end else if (bus.out_valid & ~pop) begin
            if (push) begin
               s_valid <= 1'b1;
               s_instr <= bus.imem_rdata;
               s_pc    <= tag_pc;
            end
         end else if (s_valid) begin
            bus.out_instr <= s_instr;
            bus.out_pc    <= s_pc;
            s_valid       <= push;
            if (push) begin
               s_instr <= bus.imem_rdata;
               s_pc    <= tag_pc;
            end
         end else begin
            bus.out_valid <= push;
            if (push) begin
               bus.out_instr <= bus.imem_rdata;
               bus.out_pc    <= tag_pc;
            end
         end
      end
   end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed and random stimulus checked against a delivered-PC-sequence model.
module tb_instr_fetch;
   localparam int PC_W = 9, INSTR_W = 32;
   logic               clk = 1'b0, rst_n = 1'b0;
   logic [INSTR_W-1:0] mem [512];
   int                 tests = 0, fails = 0, age = 100, n = 0;
   logic [PC_W-1:0]    exp_pc = '0, s_addr;
   logic               s_en, s_valid;
   logic [PC_W-1:0]    got [$];
   bit                 jp;
   instr_fetch_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();
   instr_fetch #(.PC_W(PC_W), .INSTR_W(INSTR_W), .FIFO_DEPTH(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   always @(posedge clk) if (bus.imem_en) bus.imem_rdata <= mem[bus.imem_addr];
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   // one clock: drive, sample 1ns later, update the model, return at the next falling edge
   task automatic cyc(input bit rdy, input bit rv = 1'b0, input logic [PC_W-1:0] rpc = '0);
      logic [INSTR_W-1:0] w;
      bus.out_ready = rdy;
      bus.redirect_valid = rv;
      bus.redirect_pc = rpc;
      #1;
      s_en = bus.imem_en;
      s_addr = bus.imem_addr;
      s_valid = bus.out_valid;
      if (age >= 1 && age <= 3) check("flush_gap", 32'(s_valid), 32'd0);
      if (age == 4) check("flush_restart", 32'(s_valid), 32'd1);
      if (s_valid) begin
         check("head_pc", 32'(bus.out_pc), 32'(exp_pc));
         check("head_instr", bus.out_instr, mem[exp_pc]);
      end
      if (s_valid && rdy) begin
         got.push_back(bus.out_pc);
         w = mem[exp_pc];
         exp_pc = (jp && w[31:26] == 6'd20) ? w[PC_W-1:0] : exp_pc + 1'b1;
      end
      if (rv) exp_pc = rpc;
      age = rv ? 1 : age + 1;
      @(negedge clk);
   endtask
   initial begin
`ifdef JUMP_PREDICT_EN
      jp = 1'b1;
`else
      jp = 1'b0;
`endif
      for (int k = 0; k < 512; k++) mem[k] = k;
      bus.out_ready = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = '0;
      repeat (3) @(negedge clk);
      check("rst_valid", 32'(bus.out_valid), 32'd0);
      check("rst_en", 32'(bus.imem_en), 32'd0);
      check("rst_addr", 32'(bus.imem_addr), 32'd0);
      check("rst_pc", 32'(bus.out_pc), 32'd0);
      check("rst_instr", bus.out_instr, 32'd0);
      rst_n = 1'b1;
      age = 1;
      exp_pc = '0;
      cyc(1);
      check("idle_no_issue", 32'(s_en), 32'd0);
      cyc(1);
      check("first_issue", 32'(s_en), 32'd1);
      check("first_addr", 32'(s_addr), 32'd0);
      cyc(1);
      repeat (10) begin
         cyc(1);
         check("stream", 32'(s_valid), 32'd1);
      end
      check("stream_count", got.size(), 32'd10);
      repeat (5) begin
         cyc(0);
         check("stall_no_issue", 32'(s_en), 32'd0);
         check("stall_held", 32'(s_valid), 32'd1);
      end
      repeat (6) begin
         cyc(1);
         check("resume", 32'(s_valid), 32'd1);
      end
      cyc(1, 1, 9'h40);
      check("redir_handshake", 32'(s_valid), 32'd1);
      n = got.size();
      repeat (8) cyc(1);
      check("redir_target", 32'(got[n]), 32'h40);
      cyc(1, 1, 9'h1FC);
      n = got.size();
      repeat (10) cyc(1);
      check("wrap_510", 32'(got[n+2]), 32'h1FE);
      check("wrap_511", 32'(got[n+3]), 32'h1FF);
      check("wrap_0", 32'(got[n+4]), 32'h0);
      check("wrap_1", 32'(got[n+5]), 32'h1);
      cyc(1, 1, 9'h10);
      cyc(1, 1, 9'h20);
      n = got.size();
      repeat (10) cyc(1);
      check("double_redir", 32'(got[n]), 32'h20);
      mem[5] = {6'd20, 10'd0, 16'h0030};
      cyc(1, 1, 9'h3);
      n = got.size();
      repeat (12) cyc(1);
      check("j_pc", 32'(got[n+2]), 32'h5);
      check("after_j", 32'(got[n+3]), jp ? 32'h30 : 32'h6);
      repeat (400) cyc($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, 9'($urandom));
      bus.out_ready = 1'b1;
      bus.redirect_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", 32'(bus.out_valid), 32'd0);
      check("arst_en", 32'(bus.imem_en), 32'd0);
      check("arst_addr", 32'(bus.imem_addr), 32'd0);
      check("arst_pc", 32'(bus.out_pc), 32'd0);
      check("arst_instr", bus.out_instr, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      age = 1;
      exp_pc = '0;
      n = got.size();
      repeat (3) cyc(1);
      repeat (6) begin
         cyc(1);
         check("arst_stream", 32'(s_valid), 32'd1);
      end
      check("arst_first", 32'(got[n]), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
